// File: rtl/udp_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module   : udp_ctrl_regs
// Purpose  : Write-side register bank for the UDPMaster control path. Header
//            fields (MAC/IP/port) are written into a shadow set; a CTRL
//            commit copies the whole shadow set atomically into the active
//            set once the transmit datapath reports idle. Writes are
//            stalled while that commit is pending.
// Ports    : clk, rst_n            - clock, synchronous active-low reset
//            reg_wr_addr/data/strb - write request from the AXI-Lite adapter
//            reg_wr_en             - request, held until reg_wr_ack
//            reg_wr_wait           - stall while a commit is pending
//            reg_wr_ack            - one-cycle write-complete pulse
//            cfg_busy              - datapath mid-packet, blocks the copy
//            cfg_enable            - CTRL.enable, applied immediately
//            cfg_src/dst_mac/ip/port - active header configuration
//            cfg_update            - one-cycle pulse when active set changes
// Revision : 1.0 - initial release
// ============================================================================
module udp_ctrl_regs #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] reg_wr_addr,
    input  logic [DATA_WIDTH-1:0] reg_wr_data,
    input  logic [STRB_WIDTH-1:0] reg_wr_strb,
    input  logic                  reg_wr_en,
    output logic                  reg_wr_wait,
    output logic                  reg_wr_ack,
    input  logic                  cfg_busy,
    output logic                  cfg_enable,
    output logic [47:0]           cfg_src_mac,
    output logic [47:0]           cfg_dst_mac,
    output logic [31:0]           cfg_src_ip,
    output logic [31:0]           cfg_dst_ip,
    output logic [15:0]           cfg_src_port,
    output logic [15:0]           cfg_dst_port,
    output logic                  cfg_update
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    localparam logic [2:0] c_IDX_CTRL       = 3'd0;
    localparam logic [2:0] c_IDX_SRC_MAC_LO = 3'd1;
    localparam logic [2:0] c_IDX_SRC_MAC_HI = 3'd2;
    localparam logic [2:0] c_IDX_SRC_IP     = 3'd3;
    localparam logic [2:0] c_IDX_DST_MAC_LO = 3'd4;
    localparam logic [2:0] c_IDX_DST_MAC_HI = 3'd5;
    localparam logic [2:0] c_IDX_DST_IP     = 3'd6;
    localparam logic [2:0] c_IDX_PORTS      = 3'd7;

    state_t                r_state;
    logic                  r_ack;
    logic                  r_update;
    logic                  r_enable;

    logic [47:0]           r_sh_src_mac;
    logic [47:0]           r_sh_dst_mac;
    logic [DATA_WIDTH-1:0] r_sh_src_ip;
    logic [DATA_WIDTH-1:0] r_sh_dst_ip;
    logic [DATA_WIDTH-1:0] r_sh_ports;

    logic [47:0]           r_act_src_mac;
    logic [47:0]           r_act_dst_mac;
    logic [DATA_WIDTH-1:0] r_act_src_ip;
    logic [DATA_WIDTH-1:0] r_act_dst_ip;
    logic [DATA_WIDTH-1:0] r_act_ports;

    logic                  w_mapped;
    logic [2:0]            w_index;
    logic                  w_accept;
    logic                  w_commit_req;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_new;
    logic                  w_unused_addr;

    assign w_mapped      = (reg_wr_addr[ADDR_WIDTH-1:5] == '0);
    assign w_index       = reg_wr_addr[4:2];
    // Byte offset within a word carries no meaning for this bank.
    assign w_unused_addr = ^reg_wr_addr[1:0];

    // The !r_ack term keeps a still-held request from being taken twice
    // in the cycle its ack is visible.
    assign w_accept      = reg_wr_en && !r_ack && (r_state == ST_IDLE);
    assign w_commit_req  = reg_wr_strb[0] && reg_wr_data[1];

    // Current contents of the addressed shadow word, merged per byte lane
    // with the incoming data. MAC_HI words read back zero above bit 15 so
    // those lanes merge to don't-care bits that are never stored.
    always_comb begin
        w_old = '0;
        case (w_index)
            c_IDX_SRC_MAC_LO: w_old = r_sh_src_mac[31:0];
            c_IDX_SRC_MAC_HI: w_old = {{(DATA_WIDTH-16){1'b0}}, r_sh_src_mac[47:32]};
            c_IDX_SRC_IP:     w_old = r_sh_src_ip;
            c_IDX_DST_MAC_LO: w_old = r_sh_dst_mac[31:0];
            c_IDX_DST_MAC_HI: w_old = {{(DATA_WIDTH-16){1'b0}}, r_sh_dst_mac[47:32]};
            c_IDX_DST_IP:     w_old = r_sh_dst_ip;
            c_IDX_PORTS:      w_old = r_sh_ports;
            default:          w_old = '0;
        endcase
        w_new = w_old;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (reg_wr_strb[i]) begin
                w_new[i*8 +: 8] = reg_wr_data[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_ack         <= 1'b0;
            r_update      <= 1'b0;
            r_enable      <= 1'b0;
            r_sh_src_mac  <= '0;
            r_sh_dst_mac  <= '0;
            r_sh_src_ip   <= '0;
            r_sh_dst_ip   <= '0;
            r_sh_ports    <= '0;
            r_act_src_mac <= '0;
            r_act_dst_mac <= '0;
            r_act_src_ip  <= '0;
            r_act_dst_ip  <= '0;
            r_act_ports   <= '0;
        end else begin
            r_ack    <= 1'b0;
            r_update <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ack <= 1'b1;
                        if (w_mapped) begin
                            case (w_index)
                                c_IDX_CTRL: begin
                                    // Enable bypasses the shadow set; the
                                    // commit bit is only an event.
                                    if (reg_wr_strb[0]) begin
                                        r_enable <= reg_wr_data[0];
                                    end
                                    if (w_commit_req) begin
                                        r_state <= ST_PENDING;
                                    end
                                end
                                c_IDX_SRC_MAC_LO: r_sh_src_mac[31:0]  <= w_new;
                                c_IDX_SRC_MAC_HI: r_sh_src_mac[47:32] <= w_new[15:0];
                                c_IDX_SRC_IP:     r_sh_src_ip         <= w_new;
                                c_IDX_DST_MAC_LO: r_sh_dst_mac[31:0]  <= w_new;
                                c_IDX_DST_MAC_HI: r_sh_dst_mac[47:32] <= w_new[15:0];
                                c_IDX_DST_IP:     r_sh_dst_ip         <= w_new;
                                c_IDX_PORTS:      r_sh_ports          <= w_new;
                                default:          r_sh_ports          <= r_sh_ports;
                            endcase
                        end
                    end
                end
                ST_PENDING: begin
                    // Copy only between packets so the datapath never sees
                    // a mix of old and new header fields.
                    if (!cfg_busy) begin
                        r_act_src_mac <= r_sh_src_mac;
                        r_act_dst_mac <= r_sh_dst_mac;
                        r_act_src_ip  <= r_sh_src_ip;
                        r_act_dst_ip  <= r_sh_dst_ip;
                        r_act_ports   <= r_sh_ports;
                        r_update      <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign reg_wr_wait  = reg_wr_en && (r_state == ST_PENDING);
    assign reg_wr_ack   = r_ack;
    assign cfg_update   = r_update;
    assign cfg_enable   = r_enable;
    assign cfg_src_mac  = r_act_src_mac;
    assign cfg_dst_mac  = r_act_dst_mac;
    assign cfg_src_ip   = r_act_src_ip;
    assign cfg_dst_ip   = r_act_dst_ip;
    assign cfg_src_port = r_act_ports[31:16];
    assign cfg_dst_port = r_act_ports[15:0];

endmodule
`default_nettype wire
